// File: rtl/omsp_spi_slave.sv
// ----------------------------------------------------------------------------
// omsp_spi_slave
//
// Memory-mapped SPI slave for the openMSP430 peripheral bus. An external SPI
// master exchanges bytes with the CPU through one transmit buffer byte and one
// receive holding byte. SCK, SS_N and MOSI are asynchronous and are
// oversampled in the mclk domain.
//
// Register map (word offsets from BASE_ADDR):
//   0 DATA   : write -> tx buffer, read -> rx buffer (read clears rx_valid)
//   1 CNTRL  : [0] cpol [1] cpha [2] rx_ie [3] tx_ie [4] en
//   2 STATUS : [0] rx_valid [1] tx_empty [2] overrun [3] underrun [4] active
//              (write 1 to bit 2/3 to clear that flag)
//
// Ports:
//   mclk, puc_rst      main clock, synchronous active-high reset
//   per_addr/din/en/we peripheral bus access (word address, low byte used)
//   per_dout           read data, zero when not selected for a read
//   sck, ss_n, mosi    SPI pins from the master (asynchronous)
//   miso, miso_oe      SPI data out and pad output enable
//   irq                level interrupt
// ----------------------------------------------------------------------------
module omsp_spi_slave #(
  parameter logic [14:0] BASE_ADDR = 15'h0160,
  parameter int          DEC_WD    = 3
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic        sck,
  input  logic        ss_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic        irq
);

  localparam int IDX_WD = DEC_WD - 1;
  localparam logic [IDX_WD-1:0] IDX_DATA   = IDX_WD'(0);
  localparam logic [IDX_WD-1:0] IDX_CNTRL  = IDX_WD'(1);
  localparam logic [IDX_WD-1:0] IDX_STATUS = IDX_WD'(2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic [4:0]  cntrl;
  logic [7:0]  tx_buf;
  logic        tx_full;
  logic [7:0]  tx_sr;
  logic [7:0]  rx_sr;
  logic [7:0]  rx_buf;
  logic        rx_valid;
  logic        overrun;
  logic        underrun;
  logic [2:0]  bit_cnt;
  logic [2:0]  sck_s;
  logic [2:0]  ss_s;
  logic [1:0]  mosi_s;

  logic        cpol, cpha, rx_ie, tx_ie, en;
  logic        reg_sel, reg_rd, reg_wr;
  logic [IDX_WD-1:0] reg_idx;
  logic        data_rd, data_wr, cntrl_wr, status_wr;
  logic        sck_rise, sck_fall, ss_fall, ss_rise;
  logic        lead_edge, trail_edge, sample_edge, shift_edge;
  logic        active, in_shift, abort, load_now, shift_now, sample_now, byte_done;
  logic        unused_bits;

  assign {en, tx_ie, rx_ie, cpha, cpol} = cntrl;

  // Bus decode: the block occupies 2^DEC_WD bytes starting at BASE_ADDR.
  assign reg_sel   = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_idx   = per_addr[IDX_WD-1:0];
  assign reg_rd    = reg_sel & (per_we == 2'b00);
  assign reg_wr    = reg_sel & per_we[0];
  assign data_rd   = reg_rd & (reg_idx == IDX_DATA);
  assign data_wr   = reg_wr & (reg_idx == IDX_DATA);
  assign cntrl_wr  = reg_wr & (reg_idx == IDX_CNTRL);
  assign status_wr = reg_wr & (reg_idx == IDX_STATUS);

  assign unused_bits = &{1'b0, per_din[15:8], per_we[1]};

  // Two-flop synchronisers on every pin, with a third flop on sck and ss_n so
  // edges are detected between the second and third stage. ss_n resets high
  // so a deselected bus never looks like a falling edge.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      sck_s  <= 3'b000;
      ss_s   <= 3'b111;
      mosi_s <= 2'b00;
    end else begin
      sck_s  <= {sck_s[1:0], sck};
      ss_s   <= {ss_s[1:0], ss_n};
      mosi_s <= {mosi_s[0], mosi};
    end
  end

  // Edge classification. The lead edge leaves the idle clock level; cpha
  // chooses whether data is sampled on the lead or the trail edge, and the
  // other edge shifts (or reloads) the transmit register.
  assign sck_rise    = sck_s[1] & ~sck_s[2];
  assign sck_fall    = ~sck_s[1] & sck_s[2];
  assign ss_fall     = ~ss_s[1] & ss_s[2];
  assign ss_rise     = ss_s[1] & ~ss_s[2];
  assign lead_edge   = cpol ? sck_fall : sck_rise;
  assign trail_edge  = cpol ? sck_rise : sck_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign active      = en & ~ss_s[1];

  // A shift edge seen with bit_cnt==0 is the byte boundary: for cpha=1 it is
  // the first lead edge of a byte, for cpha=0 it is the trail edge after the
  // 8th sample. Either way the transmit register reloads instead of shifting.
  assign in_shift   = (state == SHIFT);
  assign abort      = ss_rise | ~en;
  assign load_now   = ((state == IDLE) & ss_fall & en & ~cpha) |
                      (in_shift & ~abort & shift_edge & (bit_cnt == 3'd0));
  assign shift_now  = in_shift & ~abort & shift_edge & (bit_cnt != 3'd0);
  assign sample_now = in_shift & ~abort & sample_edge;
  assign byte_done  = sample_now & (bit_cnt == 3'd7);

  // Register file, flags and transfer FSM. Statement order sets priority:
  // software flag clears come before hardware sets, a DATA read frees the rx
  // buffer for a byte completing in the same cycle, and a DATA write lands
  // after a simultaneous load so the new byte is kept as pending.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state    <= IDLE;
      cntrl    <= 5'd0;
      tx_buf   <= 8'd0;
      tx_full  <= 1'b0;
      tx_sr    <= 8'd0;
      rx_sr    <= 8'd0;
      rx_buf   <= 8'd0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
      bit_cnt  <= 3'd0;
    end else begin
      if (cntrl_wr) cntrl <= per_din[4:0];
      if (status_wr && per_din[2]) overrun <= 1'b0;
      if (status_wr && per_din[3]) underrun <= 1'b0;
      if (data_rd) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (ss_fall && en) begin
            state   <= SHIFT;
            bit_cnt <= 3'd0;
          end
        end
        SHIFT: begin
          if (abort) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
          end else if (sample_edge) begin
            rx_sr   <= {rx_sr[6:0], mosi_s[1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (load_now) begin
        tx_sr   <= tx_full ? tx_buf : 8'hFF;
        tx_full <= 1'b0;
        if (!tx_full) underrun <= 1'b1;
      end else if (shift_now) begin
        tx_sr <= {tx_sr[6:0], 1'b0};
      end

      if (byte_done) begin
        if (!rx_valid || data_rd) begin
          rx_buf   <= {rx_sr[6:0], mosi_s[1]};
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (data_wr) begin
        tx_buf  <= per_din[7:0];
        tx_full <= 1'b1;
      end
    end
  end

  // Read mux: combinational from the current access, zero when not selected.
  always_comb begin
    per_dout = 16'h0000;
    if (reg_rd) begin
      case (reg_idx)
        IDX_DATA:   per_dout = {8'h00, rx_buf};
        IDX_CNTRL:  per_dout = {11'd0, cntrl};
        IDX_STATUS: per_dout = {11'd0, active, underrun, overrun, ~tx_full, rx_valid};
        default:    per_dout = 16'h0000;
      endcase
    end
  end

  assign miso    = tx_sr[7];
  assign miso_oe = active;
  assign irq     = (rx_ie & rx_valid) | (tx_ie & ~tx_full & en);

endmodule
